// File: rtl/bf8b_pkg.sv
// Shared constants for the core's memory bus: access-size codes, MMIO word offsets
// and STATUS register bit positions.
package bf8b_pkg;

  typedef enum logic [1:0] {
    MEM_ACC_8  = 2'd0,
    MEM_ACC_16 = 2'd1,
    MEM_ACC_32 = 2'd2
  } mem_acc_e;

  localparam logic [1:0] MMIO_CYCLE   = 2'd0;
  localparam logic [1:0] MMIO_CONSOLE = 2'd1;
  localparam logic [1:0] MMIO_STATUS  = 2'd2;
  localparam logic [1:0] MMIO_RSVD    = 2'd3;

  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_OVF       = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  // Byte-lane enables for a 32-bit bus given an access size and byte offset.
  function automatic logic [3:0] acc_wes(mem_acc_e acc, logic [1:0] byte_off);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (acc)
      MEM_ACC_8:  lanes = 4'b0001 << byte_off;
      MEM_ACC_16: lanes = byte_off[1] ? 4'b1100 : 4'b0011;
      MEM_ACC_32: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees the slot for a push in the
// same cycle, so a full FIFO accepts push+pop together.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sys_mem.sv
// Memory-side responder for the core bus: byte-writable RAM plus an MMIO window with
// a free-running cycle counter and a console TX FIFO drained by the host port.
module sys_mem
  import bf8b_pkg::*;
#(
  parameter int unsigned M_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter string       INIT_FILE   = "",
  localparam int unsigned LANES      = M_WIDTH / 8,
  localparam int unsigned ADDR_W     = M_WIDTH - $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [M_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]   wes,
  output logic [M_WIDTH-1:0] rdata,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [M_WIDTH-1:0] ram [DEPTH_WORDS];
  logic [M_WIDTH-1:0] ram_q, ram_wword;
  logic [M_WIDTH-1:0] mmio_q, mmio_d, status_word;
  logic [M_WIDTH-1:0] cycle_q;
  logic               sel_mmio_q, ovf_q;
  logic               is_mmio, ram_we;
  logic [RAM_AW-1:0]  ram_idx;
  logic [1:0]         mmio_off;
  logic               con_push, ovf_set, ovf_clr;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_addr;

  // Upper RAM index bits are don't-care: the RAM aliases across its half of the map.
  assign is_mmio     = addr[ADDR_W-1];
  assign ram_idx     = addr[RAM_AW-1:0];
  assign mmio_off    = addr[1:0];
  assign unused_addr = ^addr;

  assign ram_we   = ~rst & ~is_mmio & (|wes);
  assign con_push = ~rst & is_mmio & (mmio_off == MMIO_CONSOLE) & wes[0];
  // When full the FIFO is non-empty, so con_ready alone decides whether a slot frees up.
  assign ovf_set  = con_push & fifo_full & ~con_ready;
  assign ovf_clr  = is_mmio & (mmio_off == MMIO_STATUS) & wes[0] & wdata[STATUS_OVF];

  always_comb begin
    ram_wword = ram[ram_idx];
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wes[k]) ram_wword[k*8 +: 8] = wdata[k*8 +: 8];
    end
  end

  // ram_q samples the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= ram_wword;
    ram_q <= ram[ram_idx];
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_COUNT_LSB +: CNT_W] = fifo_count;
    status_word[STATUS_OVF]   = ovf_q;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_FULL]  = fifo_full;
    mmio_d = '0;
    case (mmio_off)
      MMIO_CYCLE:  mmio_d = cycle_q;
      MMIO_STATUS: mmio_d = status_word;
      default:     mmio_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= '0;
      mmio_q     <= '0;
      sel_mmio_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + M_WIDTH'(1);
      mmio_q     <= mmio_d;
      sel_mmio_q <= is_mmio;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Reset selects the zeroed MMIO register so rdata reads 0 without resetting the RAM path.
  assign rdata     = sel_mmio_q ? mmio_q : ram_q;
  assign con_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (con_push),
    .wdata(wdata[7:0]),
    .pop  (con_ready),
    .rdata(con_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule
